// File: rtl/compare_flag_gen.sv
// Iterative chunk-serial magnitude comparator producing less/equal flags via a start/done handshake.
// Optional macro COMPARE_EARLY_EXIT_EN: leave RUN on the first differing chunk instead of always scanning all chunks.
module compare_flag_gen #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             less_o,
    output logic             equal_o
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    logic [CHUNK-1:0] chunk_a_c, chunk_b_c;
    logic             fin_c, fin_less_c, fin_equal_c;

`ifndef COMPARE_EARLY_EXIT_EN
    logic decided_q, decided_d;
    logic dless_q, dless_d;
    logic hit_dec_c, hit_less_c;
`endif

    assign chunk_a_c = a_q[32'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b_c = b_q[32'(idx_q) * CHUNK +: CHUNK];

    // State and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            less_q  <= less_d;
            equal_q <= equal_d;
        end
    end

`ifndef COMPARE_EARLY_EXIT_EN
    // Sticky record of the highest differing chunk while the full scan continues
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            decided_q <= 1'b0;
            dless_q   <= 1'b0;
        end else begin
            decided_q <= decided_d;
            dless_q   <= dless_d;
        end
    end
`endif

    // Next-state and result logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        less_d      = less_q;
        equal_d     = equal_q;
        fin_c       = 1'b0;
        fin_less_c  = 1'b0;
        fin_equal_c = 1'b0;
`ifndef COMPARE_EARLY_EXIT_EN
        decided_d   = decided_q;
        dless_d     = dless_q;
        hit_dec_c   = decided_q;
        hit_less_c  = dless_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // Offset-binary: flipping the sign bits lets an unsigned scan give signed order
                    a_d     = signed_i ? (src1_i ^ MSB_MASK) : src1_i;
                    b_d     = signed_i ? (src2_i ^ MSB_MASK) : src2_i;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
`ifndef COMPARE_EARLY_EXIT_EN
                    decided_d = 1'b0;
                    dless_d   = 1'b0;
`endif
                end
            end

            ST_RUN: begin
`ifdef COMPARE_EARLY_EXIT_EN
                if (chunk_a_c > chunk_b_c) begin
                    fin_c = 1'b1;
                end else if (chunk_a_c < chunk_b_c) begin
                    fin_c      = 1'b1;
                    fin_less_c = 1'b1;
                end else if (idx_q == '0) begin
                    fin_c       = 1'b1;
                    fin_equal_c = 1'b1;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
`else
                if (!decided_q && (chunk_a_c != chunk_b_c)) begin
                    hit_dec_c  = 1'b1;
                    hit_less_c = (chunk_a_c < chunk_b_c);
                end
                if (idx_q == '0) begin
                    fin_c       = 1'b1;
                    fin_less_c  = hit_dec_c & hit_less_c;
                    fin_equal_c = ~hit_dec_c;
                end else begin
                    idx_d     = idx_q - IDXW'(1);
                    decided_d = hit_dec_c;
                    dless_d   = hit_less_c;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fin_c) begin
            less_d  = fin_less_c;
            equal_d = fin_equal_c;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign less_o  = less_q;
    assign equal_o = equal_q;

endmodule

// File: tb/tb_compare_flag_gen.sv
// Self-checking bench for compare_flag_gen: directed scenarios plus random compares against an arithmetic model.
module tb_compare_flag_gen;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] src1, src2;
    logic             busy, done, less, equal;

    int checks = 0;
    int errors = 0;

    compare_flag_gen #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .signed_i (sgn),
        .src1_i   (src1),
        .src2_i   (src2),
        .busy_o   (busy),
        .done_o   (done),
        .less_o   (less),
        .equal_o  (equal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference latency: cycles until the highest differing bit's chunk is reached
    function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARE_EARLY_EXIT_EN
        logic [WIDTH-1:0] x;
        x = a ^ b;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (x[i]) return NCHUNK - (i / CHUNK);
        return NCHUNK;
`else
        return NCHUNK;
`endif
    endfunction

    function automatic logic exp_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        if (s) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Issue a compare from the current cycle; optionally inject a stray start sampled at edge inj.
    // Returns positioned just after the finish edge (done visible).
    task automatic run(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input int inj);
        int  lat;
        logic busy_ok;
        start = 1'b1; sgn = s; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_start"}, 64'(busy), 64'(1));
        check({tag, ".done_clear"}, 64'(done), 64'(0));
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 3 * NCHUNK; c++) begin
            if (c == inj) begin
                start = 1'b1; sgn = 1'b1; src1 = '1; src2 = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_latency(a, b)));
        check({tag, ".busy_hold"}, 64'(busy_ok), 64'(1));
        check({tag, ".busy_end"}, 64'(busy), 64'(0));
        check({tag, ".less"}, 64'(less), 64'((a != b) && exp_less(a, b, s)));
        check({tag, ".equal"}, 64'(equal), 64'(a == b));
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check({tag, ".quiet"}, 64'(ok), 64'(1));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.less", 64'(less), 64'(0));
        check("reset.equal", 64'(equal), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Top chunk differs: early exit after one cycle
        run("t1", 32'h1000_0000, 32'h0000_0001, 1'b0, 0);
        @(posedge clk); #1;
        check("t1.done_pulse", 64'(done), 64'(0));

        // Signed vs unsigned view of the same operands
        run("t2s", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
        run("t2u", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);

        // Equal operands, then back-to-back start in the done cycle
        run("t3eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        run("t3b2b", 32'h0000_0003, 32'h0000_0005, 1'b0, 0);

        // Stray start while busy must be ignored
        @(posedge clk); #1;
        run("t4", 32'h0000_0005, 32'h0000_0009, 1'b0, 2);
        quiet("t4", 10);

        // Reset mid-compare aborts without a done pulse
        start = 1'b1; sgn = 1'b0; src1 = '0; src2 = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5.busy", 64'(busy), 64'(0));
        check("t5.done", 64'(done), 64'(0));
        check("t5.less", 64'(less), 64'(0));
        check("t5.equal", 64'(equal), 64'(0));
        quiet("t5", 10);

        // Signed boundary values
        run("sb1", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
        run("sb2", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
        run("sb3", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);

        // Random compares with a spread of differing-chunk positions
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra ^ (32'(1) << $urandom_range(0, WIDTH - 1));
                2: rb = ra;
                default: rb = ra ^ 32'($urandom_range(0, 15));
            endcase
            rs = 1'($urandom_range(0, 1));
            run("rnd", ra, rb, rs, 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
